// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped bus timer: FSM encoding,
// register offsets, MODE encodings, CTRL bit positions and byte merging.
package timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    // Byte offsets of the registers from the window base
    localparam logic [31:0] CTRL_OFF   = 32'd0;
    localparam logic [31:0] PRESET_OFF = 32'd4;
    localparam logic [31:0] COUNT_OFF  = 32'd8;

    // MODE field encodings; 1x behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    // Replace the byte lanes of old_val selected by be with those of new_val
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Three-register bus timer (CTRL, PRESET, COUNT) with one-shot and
// auto-reload modes and a maskable interrupt. Reads are combinational;
// CPU writes take effect at the clock edge and win over FSM updates.
module bus_timer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [31:0] CTRL_ADDR   = BASE + CTRL_OFF;
    localparam logic [31:0] PRESET_ADDR = BASE + PRESET_OFF;
    localparam logic [31:0] COUNT_ADDR  = BASE + COUNT_OFF;

    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       preset;
    logic [31:0]       count;
    logic              irq_flag;
    state_t            state, state_nxt;

    // Word-level decode; addr[1:0] never participates
    logic sel_ctrl, sel_preset, sel_count;
    assign sel_ctrl   = (addr[31:2] == CTRL_ADDR[31:2]);
    assign sel_preset = (addr[31:2] == PRESET_ADDR[31:2]);
    assign sel_count  = (addr[31:2] == COUNT_ADDR[31:2]);

    logic wr_any, wr_ctrl, wr_preset;
    assign wr_any    = |byteen;
    assign wr_ctrl   = sel_ctrl & wr_any;
    assign wr_preset = sel_preset & wr_any;

    logic [31:0] ctrl_word, ctrl_merged, preset_merged;
    assign ctrl_word     = {{(32-CTRL_W){1'b0}}, ctrl};
    assign ctrl_merged   = byte_merge(ctrl_word, wdata, byteen);
    assign preset_merged = byte_merge(preset, wdata, byteen);

    logic       en;
    logic [1:0] mode;
    logic       auto_reload;
    assign en          = ctrl[CTRL_EN];
    assign mode        = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
    assign auto_reload = (mode == MODE_AUTO);

    // Only CTRL[3:0] is storage; the rest of the merged word and the
    // byte offset inside a word are intentionally dropped.
    logic unused_ok;
    assign unused_ok = ^{addr[1:0], ctrl_merged[31:CTRL_W]};

    // Combinational read mux; unmapped addresses read as zero
    always_comb begin
        rdata = 32'd0;
        if (sel_ctrl)        rdata = ctrl_word;
        else if (sel_preset) rdata = preset;
        else if (sel_count)  rdata = count;
    end

    // Interrupt output depends only on registered state
    assign irq = ctrl[CTRL_IM] & irq_flag;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    logic do_load, do_dec, en_clr, flag_set;

    // Next-state logic and the datapath actions of each state
    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_dec    = 1'b0;
        en_clr    = 1'b0;
        flag_set  = 1'b0;
        case (state)
            S_IDLE: if (en) state_nxt = S_LOAD;
            S_LOAD: begin
                do_load   = 1'b1;
                state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!en)              state_nxt = S_IDLE;
                else if (count == '0) state_nxt = S_INT;
                else                  do_dec    = 1'b1;
            end
            S_INT: begin
                flag_set = 1'b1;
                if (auto_reload) begin
                    state_nxt = S_LOAD;
                end else begin
                    en_clr    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // CTRL: CPU write takes priority over the one-shot EN clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       ctrl <= '0;
        else if (wr_ctrl) ctrl <= ctrl_merged[CTRL_W-1:0];
        else if (en_clr)  ctrl[CTRL_EN] <= 1'b0;
    end

    // PRESET: plain byte-lane writable register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         preset <= '0;
        else if (wr_preset) preset <= preset_merged;
    end

    // COUNT: loaded from PRESET on LOAD, decremented in CNT, never wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       count <= '0;
        else if (do_load) count <= preset;
        else if (do_dec)  count <= count - 32'd1;
    end

    // Expiry flag: set in INT; auto-reload makes it a one-cycle pulse,
    // otherwise it holds until software touches CTRL or PRESET.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        irq_flag <= 1'b0;
        else if (flag_set) irq_flag <= 1'b1;
        else               irq_flag <= irq_flag & ~(wr_ctrl | wr_preset) & ~auto_reload;
    end

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: a register-access vector table followed by
// hand-written sequences for timing, modes, disable and reset corners.
module tb_bus_timer;

    localparam logic [31:0] B = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  byteen = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    bus_timer #(.BASE(B)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] waddr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        addr = a; byteen = be; wdata = d;
        tick();
        byteen = '0; wdata = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr = a; byteen = '0;
        #1;
        v = rdata;
    endtask

    task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        chk(name, v, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    // Count edges until irq is seen, up to limit; returns limit+1 on timeout
    task automatic edges_to_irq(input int limit, output int k);
        k = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (irq) begin
                k = i;
                break;
            end
        end
    endtask

    // Poll COUNT once per cycle until it equals target; found=0 on timeout
    task automatic wait_count(input logic [31:0] target, input int limit, output logic found);
        logic [31:0] v;
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            rd(B + 8, v);
            if (v == target) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int          k;
        int          highs;
        logic        found;
        logic [31:0] v, frozen;

        vecs[0]  = '{B + 4,  4'hF, 32'h1234_5678, B + 4,  32'h1234_5678};
        vecs[1]  = '{B + 4,  4'h2, 32'hAABB_CCDD, B + 4,  32'h1234_CC78};
        vecs[2]  = '{B + 7,  4'h8, 32'h9900_0000, B + 4,  32'h9934_CC78};
        vecs[3]  = '{B + 0,  4'hF, 32'hFFFF_FFF6, B + 0,  32'h0000_0006};
        vecs[4]  = '{B + 0,  4'hE, 32'hFFFF_FFFF, B + 0,  32'h0000_0006};
        vecs[5]  = '{B + 8,  4'hF, 32'hFFFF_FFFF, B + 8,  32'h0000_0000};
        vecs[6]  = '{B + 12, 4'hF, 32'hFFFF_FFFF, B + 12, 32'h0000_0000};
        vecs[7]  = '{32'd0,  4'h0, 32'h0,         B + 4,  32'h9934_CC78};
        vecs[8]  = '{32'd0,  4'h0, 32'h0,         B + 16, 32'h0000_0000};
        vecs[9]  = '{32'd0,  4'h0, 32'h0,         B - 4,  32'h0000_0000};
        vecs[10] = '{32'd0,  4'h0, 32'h0,         B + 2,  32'h0000_0006};
        vecs[11] = '{B + 0,  4'h1, 32'h0,         B + 0,  32'h0000_0000};

        // Reset state, before any clock edge
        #1;
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk_rd("rst_ctrl",   B + 0, 32'd0);
        chk_rd("rst_preset", B + 4, 32'd0);
        chk_rd("rst_count",  B + 8, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Register access table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].be != 4'h0) wr(vecs[i].waddr, vecs[i].be, vecs[i].wd);
            chk_rd($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end
        chk("vec_irq", {31'd0, irq}, 32'd0);

        // One-shot with IM: irq at N+4 edges, holds, EN cleared, PRESET write drops it
        do_reset();
        wr(B + 4, 4'hF, 32'd3);
        wr(B + 0, 4'hF, 32'h9);
        edges_to_irq(20, k);
        chk("oneshot_latency", k, 7);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("oneshot_hold", {31'd0, irq}, 32'd1);
        end
        chk_rd("oneshot_en_clr", B + 0, 32'h8);
        wr(B + 4, 4'hF, 32'd3);
        chk("oneshot_ack", {31'd0, irq}, 32'd0);

        // Auto-reload: first irq after N+4, then 1-cycle pulse every N+3
        do_reset();
        wr(B + 4, 4'hF, 32'd2);
        wr(B + 0, 4'hF, 32'hB);
        edges_to_irq(20, k);
        chk("auto_first", k, 6);
        for (int r = 0; r < 2; r++) begin
            for (int j = 1; j <= 5; j++) begin
                tick();
                chk($sformatf("auto_irq_r%0d_c%0d", r, j), {31'd0, irq}, (j == 5) ? 32'd1 : 32'd0);
                if (j <= 3) chk_rd($sformatf("auto_cnt_r%0d_c%0d", r, j), B + 8, 32'(3 - j));
            end
        end

        // Masked expiry: irq never rises, EN still auto-clears
        do_reset();
        wr(B + 4, 4'hF, 32'd0);
        wr(B + 0, 4'hF, 32'h1);
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (irq) highs++;
        end
        chk("masked_irq", highs, 0);
        chk_rd("masked_en_clr", B + 0, 32'h0);

        // Disable mid-count via byte-0 write: COUNT freezes, FSM idles
        do_reset();
        wr(B + 4, 4'hF, 32'd20);
        wr(B + 0, 4'hF, 32'h1);
        wait_count(32'd5, 40, found);
        chk("dis_found5", {31'd0, found}, 32'd1);
        wr(B + 0, 4'h1, 32'h0);
        tick();
        rd(B + 8, frozen);
        total++;
        if (frozen != 32'd4 && frozen != 32'd5) begin
            bad++;
            $display("FAIL dis_frozen: got %h want 4 or 5", frozen);
        end
        for (int i = 0; i < 5; i++) tick();
        chk_rd("dis_still", B + 8, frozen);
        chk("dis_irq", {31'd0, irq}, 32'd0);
        wr(B + 4, 4'hF, 32'd1);
        chk_rd("dis_preset_nocount", B + 8, frozen);
        wr(B + 0, 4'hF, 32'h9);
        edges_to_irq(20, k);
        chk("dis_restart_latency", k, 5);

        // Async reset mid-count, then no resumption after release
        do_reset();
        wr(B + 4, 4'hF, 32'd20);
        wr(B + 0, 4'hF, 32'h9);
        wait_count(32'd10, 40, found);
        chk("rst_found10", {31'd0, found}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_irq", {31'd0, irq}, 32'd0);
        chk_rd("arst_ctrl",   B + 0, 32'd0);
        chk_rd("arst_preset", B + 4, 32'd0);
        chk_rd("arst_count",  B + 8, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (irq) highs++;
        end
        chk("arst_no_irq", highs, 0);
        chk_rd("arst_count_after", B + 8, 32'd0);
        chk_rd("arst_ctrl_after",  B + 0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
